// File: rtl/ddr4_app_arb.sv
// ddr4_app_arb
//   Round-robin arbiter sharing one DDR4 MIG app interface among NREQ
//   requesters. Single-beat read/write commands are accepted one at a time
//   (IDLE -> ISSUE -> IDLE), driven onto the MIG command and write-data
//   channels, and the issuing requester of every read is queued in an
//   in-order ID FIFO so returned read data can be steered back to it.
//   Single clock domain (MIG ui_clk), synchronous active-high reset.
//
// Ports
//   clk, rst                      ui clock, synchronous active-high reset
//   req_valid/req_ready/req_we    per-requester command handshake and type
//   req_addr, req_wdata           flattened per-requester address / data
//   rsp_valid, rsp_data           one-hot read-return strobe, broadcast data
//   rsp_err                       sticky: read data arrived with no read pending
//   app_en/app_cmd/app_addr/app_rdy             MIG command channel
//   app_wdf_wren/_end/_data/_mask/app_wdf_rdy   MIG write-data channel
//   app_rd_data, app_rd_data_valid              MIG read-data channel
//   grant_cnt                     per-requester 32-bit grant counters
//
// Build option
//   DDR4_ARB_STATS_EN  when defined, grant_cnt counts accepted commands per
//                      requester; otherwise grant_cnt is constant zero.

module ddr4_app_arb #(
   parameter int NREQ     = 4,
   parameter int AW       = 28,
   parameter int DW       = 512,
   parameter int RD_DEPTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ-1:0]    req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_data,
   output logic               rsp_err,
   output logic               app_en,
   output logic [2:0]         app_cmd,
   output logic [AW-1:0]      app_addr,
   input  logic               app_rdy,
   output logic               app_wdf_wren,
   output logic               app_wdf_end,
   output logic [DW-1:0]      app_wdf_data,
   output logic [DW/8-1:0]    app_wdf_mask,
   input  logic               app_wdf_rdy,
   input  logic [DW-1:0]      app_rd_data,
   input  logic               app_rd_data_valid,
   output logic [NREQ*32-1:0] grant_cnt
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   localparam logic [2:0] CMD_WR = 3'b000;
   localparam logic [2:0] CMD_RD = 3'b001;

   logic [0:0]      state;
   logic [IW-1:0]   rr_ptr;      // first requester examined in the next search
   logic [IW-1:0]   win;
   logic [IW-1:0]   idx;
   logic [IW:0]     idx_sum;
   logic            found;
   logic [NREQ-1:0] elig;
   logic            hs;
   logic            cmd_done;
   logic            wdf_done;

   logic [IW-1:0]   id_mem [RD_DEPTH];
   logic [PW-1:0]   rd_wptr;
   logic [PW-1:0]   rd_rptr;
   logic [PW:0]     rd_count;
   logic            rd_full;
   logic            push;
   logic            pop;

   assign rd_full = (rd_count == (PW+1)'(RD_DEPTH));

   // A full read-ID FIFO only blocks reads; writes stay eligible.
   assign elig = req_valid & (req_we | {NREQ{~rd_full}});

   // Rotating search starting at rr_ptr. The index is kept modulo NREQ
   // explicitly so non power-of-two requester counts wrap correctly.
   always_comb begin
      found   = 1'b0;
      win     = '0;
      idx     = '0;
      idx_sum = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx_sum = {1'b0, rr_ptr} + (IW+1)'(k);
         if (idx_sum >= (IW+1)'(NREQ))
            idx_sum = idx_sum - (IW+1)'(NREQ);
         idx = idx_sum[IW-1:0];
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && found)
         req_ready[win] = 1'b1;
   end

   assign hs       = (state == S_IDLE) && found;
   assign push     = hs && !req_we[win];
   assign pop      = app_rd_data_valid && (rd_count != '0);
   assign cmd_done = !app_en || app_rdy;
   assign wdf_done = !app_wdf_wren || app_wdf_rdy;

   assign app_wdf_end  = app_wdf_wren;
   assign app_wdf_mask = '0;

   // Command FSM and holding registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         rr_ptr       <= '0;
         app_en       <= 1'b0;
         app_wdf_wren <= 1'b0;
         app_cmd      <= CMD_WR;
         app_addr     <= '0;
         app_wdf_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (found) begin
                  app_en       <= 1'b1;
                  app_wdf_wren <= req_we[win];
                  app_cmd      <= req_we[win] ? CMD_WR : CMD_RD;
                  app_addr     <= req_addr[win*AW +: AW];
                  app_wdf_data <= req_wdata[win*DW +: DW];
                  rr_ptr       <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // Each channel drops independently once its handshake lands.
               if (app_rdy)
                  app_en <= 1'b0;
               if (app_wdf_rdy)
                  app_wdf_wren <= 1'b0;
               if (cmd_done && wdf_done)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read-ID FIFO storage; contents need no reset since pointers are cleared.
   always_ff @(posedge clk) begin
      if (push)
         id_mem[rd_wptr] <= win;
   end

   // FIFO pointers and read-return path
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_wptr   <= '0;
         rd_rptr   <= '0;
         rd_count  <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= '0;
         if (push)
            rd_wptr <= rd_wptr + 1'b1;
         if (pop) begin
            rd_rptr                     <= rd_rptr + 1'b1;
            rsp_valid[id_mem[rd_rptr]]  <= 1'b1;
            rsp_data                    <= app_rd_data;
         end
         if (push && !pop)
            rd_count <= rd_count + 1'b1;
         else if (!push && pop)
            rd_count <= rd_count - 1'b1;
         if (app_rd_data_valid && rd_count == '0)
            rsp_err <= 1'b1;
      end
   end

`ifdef DDR4_ARB_STATS_EN
   logic [31:0] grant_q [NREQ];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREQ; i++)
            grant_q[i] <= '0;
      end else if (hs) begin
         grant_q[win] <= grant_q[win] + 32'd1;
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int unsigned i = 0; i < NREQ; i++)
         grant_cnt[i*32 +: 32] = grant_q[i];
   end
`else
   assign grant_cnt = '0;
`endif

endmodule
